// File: rtl/addsub_pkg.sv
// Shared types for the addsub operand loader.
// State encoding and operand width.
package addsub_pkg;

  localparam int OPW = 2;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, debounce, rising-edge press pulse.
// Ports: clk, rst_n, btn_raw in; level (accepted), press (1-cycle) out.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          acc;
  logic          prev;
  logic [CW-1:0] cnt;

  // Toggle on the Nth consecutive differing sample; any agreeing
  // sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      acc  <= 1'b0;
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      prev <= acc;
      if (s2 != acc) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          acc <= ~acc;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = acc;
  assign press = acc & ~prev;

endmodule

// File: rtl/addsub_operand_loader.sv
// Sequences operand entry A then B from switches and two buttons.
// Ports: clk, rst_n, sw[1:0], btn_load, btn_clr in; a1,a0,b1,b0, operands_valid, state_led[1:0] out.
module addsub_operand_loader
  import addsub_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic       a1,
  output logic       a0,
  output logic       b1,
  output logic       b0,
  output logic       operands_valid,
  output logic [1:0] state_led
);

  logic [OPW-1:0] sw_m;
  logic [OPW-1:0] sw_s;
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  state_t         state;
  state_t         state_nx;
  logic           ld_p;
  logic           clr_p;
  logic           ld_unused;
  logic           clr_unused;
  logic           ld_a;
  logic           ld_b;
  logic           legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ld (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_load),
    .level  (ld_unused),
    .press  (ld_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clr),
    .level  (clr_unused),
    .press  (clr_p)
  );

  // Clear masks load so the decode below stays one-hot.
  assign legal = (state == WAIT_A) || (state == WAIT_B) || (state == READY);
  assign ld_a  = ld_p & ~clr_p & ((state == WAIT_A) || (state == READY));
  assign ld_b  = ld_p & ~clr_p & (state == WAIT_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      clr_p:   state_nx = WAIT_A;
      ld_a:    state_nx = WAIT_B;
      ld_b:    state_nx = READY;
      default: state_nx = legal ? state : WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      unique case (1'b1)
        clr_p: begin
          a_q <= '0;
          b_q <= '0;
        end
        ld_a:    a_q <= sw_s;
        ld_b:    b_q <= sw_s;
        default: ;
      endcase
    end
  end

  always_comb begin
    operands_valid = (state == READY);
    state_led      = state;
    {a1, a0}       = a_q;
    {b1, b0}       = b_q;
  end

endmodule

// File: tb/tb_addsub_operand_loader.sv
// Bench for addsub_operand_loader with DEBOUNCE_CYCLES=4.
// Directed scenarios plus random button traffic against a history model.
module tb_addsub_operand_loader;

  localparam int N = 4;
  localparam int H = 16384;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'b00;
  logic       btn_load = 1'b0;
  logic       btn_clr = 1'b0;
  logic       a1, a0, b1, b0;
  logic       operands_valid;
  logic [1:0] state_led;

  int checks = 0;
  int failures = 0;

  addsub_operand_loader #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw            (sw),
    .btn_load      (btn_load),
    .btn_clr       (btn_clr),
    .a1            (a1),
    .a0            (a0),
    .b1            (b1),
    .b0            (b0),
    .operands_valid(operands_valid),
    .state_led     (state_led)
  );

  always #5 clk = ~clk;

  bit         rh [2][H];
  bit         ah [2][H];
  logic [1:0] swh[H];
  int         t;
  int         lt [2];
  logic [1:0] ma, mb;
  int         ms;

  function automatic bit rawv(int b, int k);
    return (k >= 1) ? rh[b][k] : 1'b0;
  endfunction

  function automatic bit accv(int b, int k);
    return (k >= 1) ? ah[b][k] : 1'b0;
  endfunction

  task automatic model_reset();
    t = 0;
    lt[0] = 0;
    lt[1] = 0;
    ma = 2'b00;
    mb = 2'b00;
    ms = 0;
  endtask

  task automatic model_edge();
    bit pr[2];
    logic [1:0] sws;
    t++;
    rh[0][t] = btn_load;
    rh[1][t] = btn_clr;
    swh[t] = sw;
    for (int b = 0; b < 2; b++) begin
      bit cur;
      bit tog;
      cur = accv(b, t - 1);
      tog = (t - lt[b] >= N);
      for (int k = t - N + 1; k <= t; k++)
        if (rawv(b, k - 2) == cur) tog = 1'b0;
      ah[b][t] = tog ? ~cur : cur;
      if (tog) lt[b] = t;
      pr[b] = accv(b, t - 1) & ~accv(b, t - 2);
    end
    sws = (t - 2 >= 1) ? swh[t - 2] : 2'b00;
    if (pr[1]) begin
      ma = 2'b00;
      mb = 2'b00;
      ms = 0;
    end else if (pr[0]) begin
      if (ms == 1) begin
        mb = sws;
        ms = 2;
      end else begin
        ma = sws;
        ms = 1;
      end
    end
  endtask

  function automatic logic [6:0] obs();
    return {a1, a0, b1, b0, operands_valid, state_led};
  endfunction

  task automatic chk(string tag, logic [6:0] o, logic [6:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("cycle", obs(), {ma, mb, ms == 2, 2'(ms)});
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic press_load(int n);
    btn_load = 1'b1;
    hold(n);
    btn_load = 1'b0;
    hold(10);
  endtask

  task automatic press_clr(int n);
    btn_clr = 1'b1;
    hold(n);
    btn_clr = 1'b0;
    hold(10);
  endtask

  initial begin
    int e;
    model_reset();
    hold(2);
    chk("reset_out", obs(), 7'b0);
    rst_n = 1'b1;

    // Load A then B, with A latency measured from E1
    sw = 2'b10;
    hold(3);
    btn_load = 1'b1;
    e = 0;
    while (e < 20 && state_led !== 2'b01) begin
      tick();
      e++;
    end
    checks++;
    assert (e == 7) else begin
      failures++;
      $error("FAIL a_latency observed=%0d expected=7", e);
    end
    hold(10 - e);
    btn_load = 1'b0;
    hold(10);
    chk("load_a", obs(), 7'b10_00_0_01);
    sw = 2'b11;
    hold(3);
    press_load(10);
    chk("load_b", obs(), 7'b10_11_1_10);

    // Bounce then a short low glitch while held: one load only
    sw = 2'b00;
    hold(3);
    for (int i = 0; i < 4; i++) begin
      btn_load = (i % 2 == 0);
      hold(2);
    end
    btn_load = 1'b1;
    hold(10);
    btn_load = 1'b0;
    hold(3);
    btn_load = 1'b1;
    hold(10);
    btn_load = 1'b0;
    hold(10);
    chk("bounce", obs(), 7'b00_11_0_01);

    // Held button from WAIT_A
    press_clr(8);
    chk("clr_wait_b", obs(), 7'b0);
    sw = 2'b11;
    hold(3);
    press_load(50);
    chk("held", obs(), 7'b11_00_0_01);

    // Build READY with A=01, B=11 via a reload from READY
    press_load(8);
    chk("ready_11", obs(), 7'b11_11_1_10);
    sw = 2'b01;
    hold(3);
    press_load(8);
    chk("reload", obs(), 7'b01_11_0_01);
    sw = 2'b11;
    hold(3);
    press_load(8);
    chk("ready_a01", obs(), 7'b01_11_1_10);
    press_clr(8);
    chk("clear", obs(), 7'b0);

    // Clear and load pulses in the same cycle
    btn_load = 1'b1;
    btn_clr = 1'b1;
    hold(8);
    btn_load = 1'b0;
    btn_clr = 1'b0;
    hold(10);
    chk("collide", obs(), 7'b0);

    // Async reset mid-press with FSM in WAIT_B
    sw = 2'b10;
    hold(3);
    press_load(8);
    chk("pre_rst", obs(), 7'b10_00_0_01);
    btn_load = 1'b1;
    hold(3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs(), 7'b0);
    model_reset();
    btn_load = 1'b0;
    hold(2);
    rst_n = 1'b1;
    hold(20);
    chk("post_rst", obs(), 7'b0);

    // Random traffic
    repeat (200) begin
      btn_load = 1'($urandom_range(0, 1));
      btn_clr = ($urandom_range(0, 6) == 0);
      sw = 2'($urandom);
      hold($urandom_range(1, 12));
    end
    btn_load = 1'b0;
    btn_clr = 1'b0;
    hold(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
